axi_sram_responder: RTL and testbench

AXI4-Lite slave that answers the probe's AXI master: a word-addressed SRAM with byte strobes, independent read and write channel FSMs, and a programmable response delay. It sits on the far end of the probe's `m_axi_*` bus in simulation and FPGA bring-up. It gives the probe's AXI commands a real target with deterministic OKAY/SLVERR behaviour.

---
 rtl/axi_resp_pkg.sv | 20 ++
 rtl/axi_sram_responder_mem.sv | 35 +++
 rtl/axi_sram_responder.sv | 213 +++++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_resp_pkg.sv
// Shared response codes and FSM state types
// for the AXI4-Lite SRAM responder.
package axi_resp_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_t;

endpackage

// File: rtl/axi_sram_responder_mem.sv
// Word SRAM with byte-enabled write port and
// registered read port; contents are never reset.
module axi_sram_responder_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Read samples before the write lands,
  // so a same-edge collision returns old data.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4-Lite SRAM target with independent read and
// write FSMs and a fixed response delay.
module axi_sram_responder
  import axi_resp_pkg::*;
#(
  parameter int          DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        m_aresetn,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arsize,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awsize,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  localparam int         AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  function automatic logic is_err(
    input logic [31:0] a,
    input logic [2:0]  sz
  );
    return (a[31:AW+2] != BASE_ADDR[31:AW+2])
        || (sz > 3'd2);
  endfunction

  logic addr_lsb_unused;
  assign addr_lsb_unused =
    ^{s_axi_araddr[1:0], s_axi_awaddr[1:0]};

  rd_state_t     r_state_q, r_state_d;
  logic [3:0]    r_cnt_q, r_cnt_d;
  logic [AW-1:0] r_idx_q, r_idx_d;
  logic          r_err_q, r_err_d;
  logic          arready_q, arready_d;
  logic          r_re;

  wr_state_t     w_state_q, w_state_d;
  logic [3:0]    w_cnt_q, w_cnt_d;
  logic [AW-1:0] w_idx_q, w_idx_d;
  logic          w_err_q, w_err_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic          aw_got_q, aw_got_d;
  logic          w_got_q, w_got_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          w_we;
  logic [31:0]   mem_rdata;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    r_idx_d   = r_idx_q;
    r_err_d   = r_err_q;
    r_re      = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          r_idx_d   = s_axi_araddr[AW+1:2];
          r_err_d   = is_err(s_axi_araddr,
                             s_axi_arsize);
          r_cnt_d   = WS;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_cnt_q == '0) begin
          r_re      = !r_err_q;
          r_state_d = R_RESP;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (s_axi_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    w_idx_d   = w_idx_q;
    w_err_d   = w_err_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    w_we      = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          aw_got_d = 1'b1;
          w_idx_d  = s_axi_awaddr[AW+1:2];
          w_err_d  = is_err(s_axi_awaddr,
                            s_axi_awsize);
        end
        if (s_axi_wvalid && wready_q) begin
          w_got_d = 1'b1;
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
        end
        if (aw_got_d && w_got_d) begin
          w_cnt_d   = WS;
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (w_cnt_q == '0) begin
          w_we      = !w_err_q;
          w_state_d = W_RESP;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_got_d;
    wready_d  = (w_state_d == W_IDLE) && !w_got_d;
  end

  always_ff @(posedge clk or negedge m_aresetn) begin
    if (!m_aresetn) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_idx_q   <= '0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      w_state_q <= W_IDLE;
      w_cnt_q   <= '0;
      w_idx_q   <= '0;
      w_err_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      r_idx_q   <= r_idx_d;
      r_err_q   <= r_err_d;
      arready_q <= arready_d;
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      w_idx_q   <= w_idx_d;
      w_err_q   <= w_err_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  axi_sram_responder_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (w_we),
    .be    (wstrb_q),
    .waddr (w_idx_q),
    .wdata (wdata_q),
    .re    (r_re),
    .raddr (r_idx_q),
    .rdata (mem_rdata)
  );

  assign s_axi_arready = arready_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_rvalid  = (r_state_q == R_RESP);
  assign s_axi_bvalid  = (w_state_q == W_RESP);

  // Error reads return zero, not stale SRAM data.
  assign s_axi_rdata =
    (s_axi_rvalid && !r_err_q) ? mem_rdata : '0;
  assign s_axi_rresp =
    (s_axi_rvalid && r_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_bresp =
    (s_axi_bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder: instance 0 has
// no wait states, instance 1 has five.
module tb_axi_sram_responder;
  import axi_resp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] araddr [2];
  logic [2:0]  arsize [2];
  logic        arvalid[2];
  logic        arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2];
  logic        rready [2];
  logic [31:0] awaddr [2];
  logic [2:0]  awsize [2];
  logic        awvalid[2];
  logic        awready[2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wvalid [2];
  logic        wready [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2];
  logic        bready [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_sram_responder #(
      .DEPTH       (256),
      .BASE_ADDR   (32'h0),
      .WAIT_STATES (g * 5)
    ) u_dut (
      .clk           (clk),
      .m_aresetn     (rst_n),
      .s_axi_araddr  (araddr[g]),
      .s_axi_arsize  (arsize[g]),
      .s_axi_arvalid (arvalid[g]),
      .s_axi_arready (arready[g]),
      .s_axi_rdata   (rdata[g]),
      .s_axi_rresp   (rresp[g]),
      .s_axi_rvalid  (rvalid[g]),
      .s_axi_rready  (rready[g]),
      .s_axi_awaddr  (awaddr[g]),
      .s_axi_awsize  (awsize[g]),
      .s_axi_awvalid (awvalid[g]),
      .s_axi_awready (awready[g]),
      .s_axi_wdata   (wdata[g]),
      .s_axi_wstrb   (wstrb[g]),
      .s_axi_wvalid  (wvalid[g]),
      .s_axi_wready  (wready[g]),
      .s_axi_bresp   (bresp[g]),
      .s_axi_bvalid  (bvalid[g]),
      .s_axi_bready  (bready[g])
    );
  end

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // Reference model: window 0..0x3FF, word memory.
  logic [31:0] mdl [2][256];

  function automatic bit acc_err(input logic [31:0] a,
                                 input logic [2:0] s);
    return (a >= 32'h400) || (s > 3'd2);
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          rp[2], awp[2], wp[2];
  bit          pv_rv[2], pv_rhs[2];
  bit          pv_bv[2], pv_bhs[2];
  int          ar_e[2], aw_e[2], w_e[2];
  logic [31:0] ar_a[2], aw_a[2], wd_m[2];
  logic [2:0]  ar_s[2], aw_s[2];
  logic [3:0]  ws_m[2];
  logic [31:0] ex_rd[2];
  logic [1:0]  ex_rr[2], ex_br[2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        rp[d] = 0; awp[d] = 0; wp[d] = 0;
        pv_rv[d] = 0; pv_rhs[d] = 0;
        pv_bv[d] = 0; pv_bhs[d] = 0;
      end else begin
        if (rvalid[d] && !pv_rv[d]) begin
          chk("m_r_pending", 32'(rp[d]), 1);
          chk("m_r_latency", cyc - ar_e[d], 1 + d*5);
          if (acc_err(ar_a[d], ar_s[d])) begin
            ex_rd[d] = '0;
            ex_rr[d] = RESP_SLVERR;
          end else begin
            ex_rd[d] = mdl[d][ar_a[d][9:2]];
            ex_rr[d] = RESP_OKAY;
          end
          rp[d] = 0;
        end
        if (rvalid[d]) begin
          chk("m_rdata", rdata[d], ex_rd[d]);
          chk("m_rresp", 32'(rresp[d]), 32'(ex_rr[d]));
          chk("m_arready_busy", 32'(arready[d]), 0);
        end
        if (pv_rv[d] && !pv_rhs[d])
          chk("m_rvalid_hold", 32'(rvalid[d]), 1);
        if (arvalid[d] && arready[d]) begin
          rp[d] = 1; ar_e[d] = cyc + 1;
          ar_a[d] = araddr[d]; ar_s[d] = arsize[d];
        end
        pv_rv[d]  = rvalid[d];
        pv_rhs[d] = rvalid[d] && rready[d];

        // Write commits after the read check so a
        // same-edge read sees the old word.
        if (bvalid[d] && !pv_bv[d]) begin
          chk("m_b_pending", 32'(awp[d] && wp[d]), 1);
          chk("m_b_latency",
              cyc - ((aw_e[d] > w_e[d]) ? aw_e[d] : w_e[d]),
              1 + d*5);
          if (acc_err(aw_a[d], aw_s[d])) begin
            ex_br[d] = RESP_SLVERR;
          end else begin
            ex_br[d] = RESP_OKAY;
            for (int i = 0; i < 4; i++)
              if (ws_m[d][i])
                mdl[d][aw_a[d][9:2]][8*i +: 8] =
                  wd_m[d][8*i +: 8];
          end
          awp[d] = 0; wp[d] = 0;
        end
        if (bvalid[d])
          chk("m_bresp", 32'(bresp[d]), 32'(ex_br[d]));
        if (pv_bv[d] && !pv_bhs[d])
          chk("m_bvalid_hold", 32'(bvalid[d]), 1);
        if (awvalid[d] && awready[d]) begin
          awp[d] = 1; aw_e[d] = cyc + 1;
          aw_a[d] = awaddr[d]; aw_s[d] = awsize[d];
        end
        if (wvalid[d] && wready[d]) begin
          wp[d] = 1; w_e[d] = cyc + 1;
          wd_m[d] = wdata[d]; ws_m[d] = wstrb[d];
        end
        pv_bv[d]  = bvalid[d];
        pv_bhs[d] = bvalid[d] && bready[d];
      end
    end
  end

  task automatic do_write(input int d,
                          input logic [31:0] a,
                          input logic [2:0] sz,
                          input logic [31:0] dat,
                          input logic [3:0] strb,
                          input int lead,
                          input logic [1:0] exp_b,
                          input string nm);
    bit awd = 0, wdn = 0, hsa, hsw;
    int k = 0;
    @(posedge clk); #1;
    awaddr[d] = a; awsize[d] = sz;
    wdata[d] = dat; wstrb[d] = strb;
    wvalid[d] = 1; awvalid[d] = (lead == 0);
    bready[d] = 1;
    while (!(awd && wdn) && k < 40) begin
      @(negedge clk);
      if (wdn && !awd)
        chk({nm, "_wready_low"}, 32'(wready[d]), 0);
      hsa = awvalid[d] && awready[d];
      hsw = wvalid[d] && wready[d];
      @(posedge clk); #1;
      k++;
      if (hsa) begin awd = 1; awvalid[d] = 0; end
      if (hsw) begin wdn = 1; wvalid[d] = 0; end
      if (k == lead) awvalid[d] = 1;
    end
    chk({nm, "_addr_data_hs"}, 32'(awd && wdn), 1);
    k = 0;
    do begin @(negedge clk); k++; end
    while (!bvalid[d] && k < 40);
    chk({nm, "_bvalid"}, 32'(bvalid[d]), 1);
    chk({nm, "_bresp"}, 32'(bresp[d]), 32'(exp_b));
    @(posedge clk); #1;
    bready[d] = 0;
  endtask

  task automatic do_read(input int d,
                         input logic [31:0] a,
                         input logic [2:0] sz,
                         input int hold,
                         input logic [31:0] exp_d,
                         input logic [1:0] exp_r,
                         input string nm);
    int k = 0;
    @(posedge clk); #1;
    araddr[d] = a; arsize[d] = sz;
    arvalid[d] = 1; rready[d] = 0;
    do begin @(negedge clk); k++; end
    while (!arready[d] && k < 40);
    chk({nm, "_arready"}, 32'(arready[d]), 1);
    @(posedge clk); #1;
    arvalid[d] = 0;
    k = 0;
    do begin @(negedge clk); k++; end
    while (!rvalid[d] && k < 40);
    chk({nm, "_rvalid"}, 32'(rvalid[d]), 1);
    chk({nm, "_rdata"}, rdata[d], exp_d);
    chk({nm, "_rresp"}, 32'(rresp[d]), 32'(exp_r));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_stall_rdata"}, rdata[d], exp_d);
      chk({nm, "_stall_arready"}, 32'(arready[d]), 0);
    end
    @(posedge clk); #1;
    rready[d] = 1;
    @(posedge clk); #1;
    rready[d] = 0;
    @(negedge clk);
    chk({nm, "_arready_back"}, 32'(arready[d]), 1);
  endtask

  task automatic chk_quiet(input int d, input string nm);
    chk({nm, "_arready"}, 32'(arready[d]), 0);
    chk({nm, "_awready"}, 32'(awready[d]), 0);
    chk({nm, "_wready"}, 32'(wready[d]), 0);
    chk({nm, "_rvalid"}, 32'(rvalid[d]), 0);
    chk({nm, "_bvalid"}, 32'(bvalid[d]), 0);
    chk({nm, "_rdata"}, rdata[d], 0);
    chk({nm, "_rresp"}, 32'(rresp[d]), 0);
    chk({nm, "_bresp"}, 32'(bresp[d]), 0);
  endtask

  task automatic chk_ready(input int d, input string nm);
    chk({nm, "_arready"}, 32'(arready[d]), 1);
    chk({nm, "_awready"}, 32'(awready[d]), 1);
    chk({nm, "_wready"}, 32'(wready[d]), 1);
  endtask

  initial begin
    rst_n = 0;
    for (int d = 0; d < 2; d++) begin
      araddr[d] = '0; arsize[d] = '0; arvalid[d] = 0;
      rready[d] = 0; awaddr[d] = '0; awsize[d] = '0;
      awvalid[d] = 0; wdata[d] = '0; wstrb[d] = '0;
      wvalid[d] = 0; bready[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_quiet(0, "rst0");
    chk_quiet(1, "rst1");
    rst_n = 1;
    @(posedge clk); #1;
    chk_ready(0, "rel0");
    chk_ready(1, "rel1");

    do_write(0, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF,
             0, RESP_OKAY, "t1_wr");
    do_read(0, 32'h10, 3'd2, 0, 32'hDEADBEEF,
            RESP_OKAY, "t1_rd");

    do_write(0, 32'h20, 3'd2, 32'h11223344, 4'hF,
             0, RESP_OKAY, "t2_wr_a");
    do_write(0, 32'h20, 3'd2, 32'hAABBCCDD, 4'b0101,
             0, RESP_OKAY, "t2_wr_b");
    do_read(0, 32'h20, 3'd2, 0, 32'h11BB33DD,
            RESP_OKAY, "t2_rd");

    do_write(0, 32'h30, 3'd2, 32'hCAFE0001, 4'hF,
             4, RESP_OKAY, "t3_w_first");
    do_read(0, 32'h30, 3'd2, 0, 32'hCAFE0001,
            RESP_OKAY, "t3_rd_a");
    do_write(0, 32'h37, 3'd1, 32'h5A5A0F0F, 4'hF,
             0, RESP_OKAY, "t3_same_edge");
    do_read(0, 32'h34, 3'd0, 0, 32'h5A5A0F0F,
            RESP_OKAY, "t3_rd_b");

    do_read(0, 32'h400, 3'd2, 0, 32'h0,
            RESP_SLVERR, "t4_rd_miss");
    do_write(0, 32'h20, 3'd3, 32'h0, 4'hF,
             0, RESP_SLVERR, "t4_wr_size");
    do_read(0, 32'h20, 3'd2, 0, 32'h11BB33DD,
            RESP_OKAY, "t4_rd_kept");
    do_read(0, 32'h20, 3'd4, 0, 32'h0,
            RESP_SLVERR, "t4_rd_size");

    do_write(1, 32'h50, 3'd2, 32'h01234567, 4'hF,
             0, RESP_OKAY, "t5_wr");
    do_read(1, 32'h50, 3'd2, 10, 32'h01234567,
            RESP_OKAY, "t5_rd");

    do_write(1, 32'h40, 3'd2, 32'h0BADF00D, 4'hF,
             2, RESP_OKAY, "t6_wr_a");
    @(posedge clk); #1;
    awaddr[1] = 32'h40; awsize[1] = 3'd2;
    wdata[1] = 32'hFFFFFFFF; wstrb[1] = 4'hF;
    awvalid[1] = 1; wvalid[1] = 1; bready[1] = 0;
    @(negedge clk);
    chk("t6_hs", 32'(awready[1] && wready[1]), 1);
    @(posedge clk); #1;
    awvalid[1] = 0; wvalid[1] = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk_quiet(1, "t6_rst1");
    chk_quiet(0, "t6_rst0");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    chk_ready(1, "t6_rel1");
    chk_ready(0, "t6_rel0");
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t6_no_bvalid", 32'(bvalid[1]), 0);
    end
    do_read(1, 32'h40, 3'd2, 0, 32'h0BADF00D,
            RESP_OKAY, "t6_rd");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
